// File: rtl/traffic_phase_fsm.sv
// rtl/traffic_phase_fsm.sv - main/side traffic phase sequencer; optional WALK phase under PED_WALK_EN
module traffic_phase_fsm #(
  parameter int GREEN_TICKS  = 3,
  parameter int SIDE_TICKS   = 2,
  parameter int YELLOW_TICKS = 1,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_long,
  input  logic       tick_short,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       timer_clr,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    WALK        = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Last tick_cnt value of each phase: a qualifying tick seen at this count ends the phase.
  localparam logic [3:0] GREEN_LAST  = 4'(GREEN_TICKS - 1);
  localparam logic [3:0] SIDE_LAST   = 4'(SIDE_TICKS - 1);
  localparam logic [3:0] YELLOW_LAST = 4'(YELLOW_TICKS - 1);
  localparam logic [3:0] ALLRED_LAST = 4'(ALLRED_TICKS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] tick_cnt;
  logic       side_latch;
  logic       uses_long;
  logic       qual_tick;
  logic       changing;
  logic       ped_pending;

`ifdef PED_WALK_EN
  localparam logic [3:0] WALK_LAST = 4'(WALK_TICKS - 1);
  logic ped_latch;

  // Pedestrian demand latch; the edge entering WALK clears it even if ped_req is still high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ped_latch <= 1'b0;
    else if (changing && state_nxt == WALK) ped_latch <= 1'b0;
    else ped_latch <= ped_latch | ped_req;
  end

  assign ped_pending = ped_latch;
`else
  logic       unused_ped;
  logic [3:0] unused_walk_ticks;
  assign unused_ped        = ped_req;
  assign unused_walk_ticks = 4'(WALK_TICKS);
  assign ped_pending       = 1'b0;
`endif

  // Next-state decode and Moore light outputs from the state register.
  always_comb begin
    state_nxt  = state;
    main_light = RED;
    side_light = RED;
    walk       = 1'b0;
    uses_long  = (state == MAIN_GREEN) || (state == SIDE_GREEN) || (state == WALK);
    // The timer is restarting while timer_clr is high, so a tick in that cycle is stale.
    qual_tick  = !timer_clr && (uses_long ? tick_long : tick_short);
    case (state)
      MAIN_GREEN: begin
        main_light = GREEN;
        if (qual_tick && tick_cnt >= GREEN_LAST && (side_latch || side_req))
          state_nxt = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        main_light = YELLOW;
        if (qual_tick && tick_cnt == YELLOW_LAST) state_nxt = ALL_RED_1;
      end
      ALL_RED_1: begin
        if (qual_tick && tick_cnt == ALLRED_LAST) state_nxt = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        side_light = GREEN;
        if (qual_tick && tick_cnt == SIDE_LAST) state_nxt = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        side_light = YELLOW;
        if (qual_tick && tick_cnt == YELLOW_LAST) state_nxt = ALL_RED_2;
      end
      ALL_RED_2: begin
        if (qual_tick && tick_cnt == ALLRED_LAST)
          state_nxt = ped_pending ? WALK : MAIN_GREEN;
      end
`ifdef PED_WALK_EN
      WALK: begin
        walk = 1'b1;
        if (qual_tick && tick_cnt == WALK_LAST) state_nxt = MAIN_GREEN;
      end
`endif
      default: state_nxt = ALL_RED_2;
    endcase
    changing = (state_nxt != state);
  end

  // State, phase tick counter, registered timer restart pulse and side demand latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MAIN_GREEN;
      tick_cnt   <= 4'd0;
      timer_clr  <= 1'b0;
      side_latch <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer_clr <= changing;
      if (changing) tick_cnt <= 4'd0;
      else if (qual_tick && tick_cnt != 4'd15) tick_cnt <= tick_cnt + 4'd1;
      if (changing && state_nxt == SIDE_GREEN) side_latch <= 1'b0;
      else side_latch <= side_latch | side_req;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// tb/tb_traffic_phase_fsm.sv - directed self-checking bench for traffic_phase_fsm
module tb_traffic_phase_fsm;

  logic       clk;
  logic       rst;
  logic       tick_long;
  logic       tick_short;
  logic       side_req;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       timer_clr;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  traffic_phase_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .tick_long  (tick_long),
    .tick_short (tick_short),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .timer_clr  (timer_clr),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {main_light, side_light} for each phase encoding.
  function automatic logic [5:0] lights_of(input logic [2:0] ph);
    case (ph)
      3'd0:    lights_of = 6'b001_100;
      3'd1:    lights_of = 6'b010_100;
      3'd3:    lights_of = 6'b100_001;
      3'd4:    lights_of = 6'b100_010;
      default: lights_of = 6'b100_100;
    endcase
  endfunction

  task automatic expect_st(input string tag, input logic [2:0] ph, input logic tc);
    check_eq({tag, ".phase"}, 8'(phase), 8'(ph));
    check_eq({tag, ".lights"}, 8'({main_light, side_light}), 8'(lights_of(ph)));
    check_eq({tag, ".walk"}, 8'(walk), 8'(ph == 3'd6));
    check_eq({tag, ".timer_clr"}, 8'(timer_clr), 8'(tc));
  endtask

  // Called at a negedge: drive inputs through one posedge, clear them at the next negedge.
  task automatic step(input logic tl, input logic ts, input logic sr, input logic pr);
    tick_long  = tl;
    tick_short = ts;
    side_req   = sr;
    ped_req    = pr;
    @(negedge clk);
    tick_long  = 1'b0;
    tick_short = 1'b0;
    side_req   = 1'b0;
    ped_req    = 1'b0;
  endtask

  initial begin
    logic [2:0] prev;
    logic       safe;
    rst = 1'b0; tick_long = 1'b0; tick_short = 1'b0; side_req = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    expect_st("reset", 3'd0, 1'b0);
    rst = 1'b1;

    // Latched side demand, minimum main green, full side cycle.
    step(0, 0, 1, 0); expect_st("side_pulse", 3'd0, 1'b0);
    step(1, 0, 0, 0); expect_st("mg_tick1", 3'd0, 1'b0);
    step(1, 0, 0, 0); expect_st("mg_tick2", 3'd0, 1'b0);
    step(1, 0, 0, 0); expect_st("mg_exit", 3'd1, 1'b1);
    step(0, 1, 0, 0); expect_st("y_clr_tick", 3'd1, 1'b0);
    step(1, 0, 0, 0); expect_st("y_long_ign", 3'd1, 1'b0);
    step(0, 1, 0, 0); expect_st("y_exit", 3'd2, 1'b1);
    step(0, 1, 0, 0); expect_st("ar1_clr_tick", 3'd2, 1'b0);
    step(0, 1, 0, 0); expect_st("ar1_exit", 3'd3, 1'b1);
    step(1, 1, 0, 0); expect_st("sg_clr_tick", 3'd3, 1'b0);
    step(1, 1, 0, 0); expect_st("sg_tick1", 3'd3, 1'b0);
    step(0, 1, 0, 1); expect_st("sg_short_ign", 3'd3, 1'b0);
    step(1, 0, 0, 0); expect_st("sg_exit", 3'd4, 1'b1);
    step(0, 0, 0, 0); expect_st("sy_idle", 3'd4, 1'b0);
    step(0, 1, 0, 0); expect_st("sy_exit", 3'd5, 1'b1);
    step(0, 0, 0, 0); expect_st("ar2_idle", 3'd5, 1'b0);
    step(0, 1, 0, 0);
`ifdef PED_WALK_EN
    expect_st("ar2_walk", 3'd6, 1'b1);
    step(0, 0, 0, 0); expect_st("walk_idle", 3'd6, 1'b0);
    step(1, 0, 0, 0); expect_st("walk_tick1", 3'd6, 1'b0);
    step(1, 0, 0, 0); expect_st("walk_exit", 3'd0, 1'b1);
`else
    expect_st("ar2_exit", 3'd0, 1'b1);
`endif
    step(0, 0, 0, 0); expect_st("mg_idle", 3'd0, 1'b0);

    // No demand: main green holds and the counter saturates instead of wrapping.
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0); expect_st("mg_hold", 3'd0, 1'b0);
    end
    step(1, 0, 1, 0); expect_st("mg_sat_demand", 3'd1, 1'b1);

    // side_req high on the edge entering SIDE_GREEN: the clear wins.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); expect_st("ar1_b", 3'd2, 1'b1);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0); expect_st("sg_enter_req", 3'd3, 1'b1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); expect_st("sg_exit_b", 3'd4, 1'b1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); expect_st("sy_exit_b", 3'd5, 1'b1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); expect_st("ar2_exit_b", 3'd0, 1'b1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0); expect_st("latch_clr_wins", 3'd0, 1'b0);
    end

    // Reach SIDE_YELLOW with the side latch set, then reset asynchronously.
    step(1, 0, 1, 0); expect_st("mg_exit_c", 3'd1, 1'b1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); expect_st("sg_enter_c", 3'd3, 1'b1);
    step(0, 0, 1, 0); expect_st("sg_side_req", 3'd3, 1'b0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); expect_st("sy_before_rst", 3'd4, 1'b1);
    step(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 expect_st("rst_async", 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0); expect_st("rst_latch_lost", 3'd0, 1'b0);
    end

    // Both ticks every cycle with random demand: lights stay safe, timer_clr marks each change.
    for (int i = 0; i < 200; i++) begin
      prev       = phase;
      tick_long  = 1'b1;
      tick_short = 1'b1;
      side_req   = 1'($urandom_range(0, 1));
      @(negedge clk);
      safe = $onehot(main_light) && $onehot(side_light) &&
             !(main_light != 3'b100 && side_light != 3'b100);
      check_eq("safety", 8'(safe), 8'd1);
      check_eq("clr_on_change", 8'(timer_clr), 8'(phase != prev));
    end
    tick_long = 1'b0; tick_short = 1'b0; side_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
